// File: rtl/bip_debug_unit.sv
// -----------------------------------------------------------------------------
// bip_debug_unit
//
// Run-control and result-dump stage between the UART byte interface and the
// BIP CPU. It waits for a start command byte, then enables the CPU until a HALT
// opcode is seen (or the cycle counter reaches TIMEOUT). It then streams a
// 6-byte frame {PC, ACC, CNT} (16 bits each, MSB first) to the UART transmitter.
//
// Parameters:
//   PC_W      width of the CPU program address (zero-extended to 16 bits)
//   DATA_W    width of the CPU accumulator
//   CNT_W     width of the executed-cycle counter
//   START_CMD RX byte that launches a run
//   TIMEOUT   cycle count that forces a dump when no HALT is seen
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous, active-low reset
//   RX_DATA      received UART byte, valid while RX_DONE is high
//   RX_DONE      one-cycle receive strobe
//   TX_DONE      one-cycle strobe: current TX byte finished
//   INSTRUCTION  CPU instruction word, opcode in [15:11]
//   ADDR_PM      CPU program counter
//   ACC          CPU accumulator
//   CPU_EN       CPU clock enable (combinational)
//   TX_START     one-cycle strobe launching TX_DATA
//   TX_DATA      byte to transmit
//   BUSY         high whenever the block is not idle
// -----------------------------------------------------------------------------
module bip_debug_unit #(
  parameter int unsigned      PC_W      = 11,
  parameter int unsigned      DATA_W    = 16,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [7:0]       START_CMD = 8'h73,
  parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(16'hFFFF)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_DONE,
  input  logic              TX_DONE,
  input  logic [15:0]       INSTRUCTION,
  input  logic [PC_W-1:0]   ADDR_PM,
  input  logic [DATA_W-1:0] ACC,
  output logic              CPU_EN,
  output logic              TX_START,
  output logic [7:0]        TX_DATA,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SEND    = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd5;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [47:0]      r_shift;
  logic [47:0]      w_shift_next;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_next;

  logic             w_halt;
  logic             w_timeout;
  logic             w_start_cmd;
  logic [15:0]      w_pc16;
  logic [15:0]      w_acc16;
  logic [15:0]      w_cnt16;
  logic [47:0]      w_frame;
  logic             w_unused_operand;

  assign w_halt      = (INSTRUCTION[15:11] == 5'b00000);
  assign w_timeout   = (r_count == TIMEOUT);
  assign w_start_cmd = RX_DONE && (RX_DATA == START_CMD);

  // Only the opcode field matters here; operand bits are deliberately ignored.
  assign w_unused_operand = ^INSTRUCTION[10:0];

  assign w_pc16  = 16'(ADDR_PM);
  assign w_acc16 = 16'(ACC);
  assign w_cnt16 = 16'(r_count);
  assign w_frame = {w_pc16, w_acc16, w_cnt16};

  // The outgoing byte is always the top of the shift register, so it holds
  // steady through WAIT_TX and reads as zero after reset.
  assign TX_DATA = r_shift[47:40];
  assign BUSY    = (r_state != IDLE);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_count <= '0;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_count_next;
      r_shift <= w_shift_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_count_next = r_count;
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    CPU_EN       = 1'b0;
    TX_START     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_start_cmd) begin
          w_next_state = RUN;
          w_count_next = '0;
        end
      end

      RUN: begin
        // CPU_EN is gated combinationally so the HALT instruction is never
        // executed and the PC stays on the HALT address for the dump.
        CPU_EN = !w_halt && !w_timeout;
        if (w_halt || w_timeout) begin
          w_shift_next = w_frame;
          w_idx_next   = '0;
          w_next_state = SEND;
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end

      SEND: begin
        TX_START     = 1'b1;
        w_next_state = WAIT_TX;
      end

      WAIT_TX: begin
        if (TX_DONE) begin
          w_shift_next = {r_shift[39:0], 8'h00};
          w_idx_next   = r_idx + 3'd1;
          w_next_state = (r_idx == LAST_IDX) ? IDLE : SEND;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bip_debug_unit.sv
// -----------------------------------------------------------------------------
// tb_bip_debug_unit
//
// Bench for bip_debug_unit. A small clocked BIP CPU stub (program memory, PC,
// ACC, 16-word data memory) sits behind CPU_EN. Expected frames come from an
// instruction-level interpreter of the loaded program. Two DUT instances are
// used: one with the default TIMEOUT and one with TIMEOUT=10; 'sel' routes the
// strobes and the monitored outputs to one of them.
// -----------------------------------------------------------------------------
module tb_bip_debug_unit;

  localparam logic [7:0] START_CMD = 8'h73;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rx_done, tx_done, sel;
  logic [7:0]  rx_data;
  logic [15:0] instr;
  logic [10:0] m_pc;
  logic [15:0] m_acc;
  logic [15:0] pmem [0:2047];
  logic [15:0] m_dm [0:15];
  logic        cpu_load;
  logic [15:0] load_acc;

  logic       en_a, st_a, busy_a, en_b, st_b, busy_b;
  logic [7:0] txd_a, txd_b;
  logic       rx_done_a, rx_done_b, tx_done_a, tx_done_b;
  logic       cpu_en, tx_start, busy;
  logic [7:0] tx_data;

  assign rx_done_a = rx_done & ~sel;
  assign rx_done_b = rx_done & sel;
  assign tx_done_a = tx_done & ~sel;
  assign tx_done_b = tx_done & sel;
  assign cpu_en    = sel ? en_b  : en_a;
  assign tx_start  = sel ? st_b  : st_a;
  assign busy      = sel ? busy_b : busy_a;
  assign tx_data   = sel ? txd_b : txd_a;
  assign instr     = pmem[m_pc];

  bip_debug_unit dut_a (
    .CLK(clk), .RESET(rst_n), .RX_DATA(rx_data), .RX_DONE(rx_done_a),
    .TX_DONE(tx_done_a), .INSTRUCTION(instr), .ADDR_PM(m_pc), .ACC(m_acc),
    .CPU_EN(en_a), .TX_START(st_a), .TX_DATA(txd_a), .BUSY(busy_a)
  );

  bip_debug_unit #(.TIMEOUT(16'd10)) dut_b (
    .CLK(clk), .RESET(rst_n), .RX_DATA(rx_data), .RX_DONE(rx_done_b),
    .TX_DONE(tx_done_b), .INSTRUCTION(instr), .ADDR_PM(m_pc), .ACC(m_acc),
    .CPU_EN(en_b), .TX_START(st_b), .TX_DATA(txd_b), .BUSY(busy_b)
  );

  // BIP CPU stub: executes one instruction per enabled cycle.
  always @(posedge clk) begin
    if (cpu_load) begin
      m_pc  <= '0;
      m_acc <= load_acc;
      for (int i = 0; i < 16; i++) m_dm[i] <= '0;
    end else if (cpu_en) begin
      case (instr[15:11])
        5'd1: m_dm[instr[3:0]] <= m_acc;
        5'd2: m_acc <= m_dm[instr[3:0]];
        5'd3: m_acc <= {5'b0, instr[10:0]};
        5'd4: m_acc <= m_acc + m_dm[instr[3:0]];
        5'd5: m_acc <= m_acc + {5'b0, instr[10:0]};
        5'd6: m_acc <= m_acc - m_dm[instr[3:0]];
        5'd7: m_acc <= m_acc - {5'b0, instr[10:0]};
        default: ;
      endcase
      m_pc <= m_pc + 11'd1;
    end
  end

  int n_cmp, n_fail;

  // Results of the last do_run
  logic [7:0] got_frame [0:5];
  int   got_en, got_starts, got_acks, got_first_tx, gap_err, hold_err, extra_err, hung;
  logic got_first_en, got_first_busy;

  // Instruction-level interpreter: runs the program until HALT or tmo
  // executed instructions, returns the expected {PC, ACC, CNT} frame.
  function automatic logic [47:0] ref_frame(input logic [15:0] acc0, input int tmo,
                                            output int cnt);
    int pc;
    logic [15:0] a, w, imm;
    logic [15:0] dm [16];
    pc = 0; a = acc0; cnt = 0;
    foreach (dm[i]) dm[i] = '0;
    while (pmem[pc][15:11] != 5'd0 && cnt != tmo) begin
      w = pmem[pc];
      imm = {5'b0, w[10:0]};
      case (w[15:11])
        5'd1: dm[w[3:0]] = a;
        5'd2: a = dm[w[3:0]];
        5'd3: a = imm;
        5'd4: a = a + dm[w[3:0]];
        5'd5: a = a + imm;
        5'd6: a = a - dm[w[3:0]];
        5'd7: a = a - imm;
        default: ;
      endcase
      pc = (pc + 1) % 2048;
      cnt++;
    end
    return {16'(pc), a, 16'(cnt)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 2048; i++) pmem[i] = 16'h0000;
  endtask

  task automatic set_normal_prog();
    clear_prog();
    pmem[0] = 16'h1804; // LDI 4
    pmem[1] = 16'h0802; // STO 2
    pmem[2] = 16'h2804; // ADDI 4
    pmem[3] = 16'h0000; // HALT
  endtask

  task automatic load_cpu(input logic [15:0] acc0);
    @(posedge clk); #1;
    load_acc = acc0;
    cpu_load = 1'b1;
    @(posedge clk); #1;
    cpu_load = 1'b0;
  endtask

  // Launch a run and act as the UART transmitter until the dump finishes.
  // Loop cycle 0 is the first cycle in RUN.
  task automatic do_run(input int max_dly, input bit noise);
    int  pend_cnt, done_c;
    bit  pending, exp_start, exp_idle;
    got_en = 0; got_starts = 0; got_acks = 0; got_first_tx = -1;
    gap_err = 0; hold_err = 0; extra_err = 0; hung = 0;
    got_first_en = 1'bx; got_first_busy = 1'bx;
    pending = 0; exp_start = 0; exp_idle = 0; done_c = -1; pend_cnt = 0;
    foreach (got_frame[i]) got_frame[i] = 8'hxx;
    @(posedge clk); #1;
    rx_data = START_CMD;
    rx_done = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rx_done = 1'b0;
      tx_done = 1'b0;
      if (c == 0) begin
        got_first_en   = cpu_en;
        got_first_busy = busy;
        if (noise) begin rx_done = 1'b1; rx_data = START_CMD; end
      end
      if (cpu_en) got_en++;
      if (exp_start) begin
        if (tx_start !== 1'b1) gap_err++;
        exp_start = 0;
      end
      if (exp_idle) begin
        if (busy !== 1'b0) gap_err++;
        exp_idle = 0;
      end
      if (tx_start) begin
        if (pending || got_acks >= 6) extra_err++;
        if (got_starts < 6) got_frame[got_starts] = tx_data;
        if (got_starts == 0) got_first_tx = c;
        got_starts++;
        pending  = 1;
        pend_cnt = $urandom_range(max_dly, 0);
        if (noise) begin
          tx_done = 1'b1;          // lands on the SEND cycle
          rx_done = 1'b1;
          rx_data = START_CMD;
        end
      end else if (pending) begin
        if (got_starts >= 1 && got_starts <= 6 && tx_data !== got_frame[got_starts-1])
          hold_err++;
        if (pend_cnt == 0) begin
          tx_done = 1'b1;
          pending = 0;
          got_acks++;
          if (got_acks < 6) exp_start = 1;
          else begin exp_idle = 1; done_c = c; end
        end else begin
          pend_cnt--;
        end
      end
      if (done_c >= 0 && c >= done_c + 6) break;
    end
    rx_done = 1'b0;
    tx_done = 1'b0;
    if (done_c < 0) hung = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_done = 1'b1; rx_data = START_CMD;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en[%0d]: got %b expected 0", k, cpu_en); end
      n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start[%0d]: got %b expected 0", k, tx_start); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy); end
      n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data[%0d]: got %h expected 00", k, tx_data); end
    end
    rst_n = 1'b1; rx_done = 1'b0; cpu_load = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_release_cpu_en: got %b expected 0", cpu_en); end
  endtask

  task automatic test_normal_run();
    set_normal_prog();
    load_cpu(16'h5A5A);
    do_run(3, 0);
    n_cmp++; if ({got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]} !== 48'h0003_0008_0003) begin
      n_fail++; $display("FAIL normal_frame: got %h %h %h %h %h %h expected 00 03 00 08 00 03",
        got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]); end
    n_cmp++; if (got_en !== 3) begin n_fail++; $display("FAIL normal_cpu_en_cycles: got %0d expected 3", got_en); end
    n_cmp++; if (got_first_en !== 1'b1) begin n_fail++; $display("FAIL normal_start_latency: got %b expected 1", got_first_en); end
    n_cmp++; if (got_first_busy !== 1'b1) begin n_fail++; $display("FAIL normal_busy: got %b expected 1", got_first_busy); end
    n_cmp++; if (got_first_tx !== 4) begin n_fail++; $display("FAIL normal_halt_to_tx: got %0d expected 4", got_first_tx); end
    n_cmp++; if (got_starts !== 6 || got_acks !== 6) begin n_fail++; $display("FAIL normal_byte_count: got %0d/%0d expected 6/6", got_starts, got_acks); end
    n_cmp++; if (gap_err + hold_err + extra_err + hung !== 0) begin n_fail++; $display("FAIL normal_handshake: got gap=%0d hold=%0d extra=%0d hung=%0d expected all 0", gap_err, hold_err, extra_err, hung); end
  endtask

  task automatic test_wrong_cmd();
    set_normal_prog();
    load_cpu(16'h0000);
    @(posedge clk); #1;
    rx_data = 8'h41; rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (busy !== 1'b0 || cpu_en !== 1'b0) begin n_fail++; $display("FAIL wrong_cmd_idle[%0d]: got busy=%b cpu_en=%b expected 0/0", k, busy, cpu_en); end
      @(posedge clk); #1;
    end
    do_run(2, 0);
    n_cmp++; if ({got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]} !== 48'h0003_0008_0003) begin
      n_fail++; $display("FAIL wrong_cmd_then_start_frame: got %h %h %h %h %h %h expected 00 03 00 08 00 03",
        got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]); end
    n_cmp++; if (got_en !== 3) begin n_fail++; $display("FAIL wrong_cmd_then_start_en: got %0d expected 3", got_en); end
  endtask

  task automatic test_immediate_halt();
    logic [15:0] acc0;
    acc0 = 16'($urandom_range(65535, 0));
    clear_prog();
    load_cpu(acc0);
    do_run(4, 0);
    n_cmp++; if ({got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]} !== {16'h0000, acc0, 16'h0000}) begin
      n_fail++; $display("FAIL imm_halt_frame: got %h %h %h %h %h %h expected 00 00 %h 00 00",
        got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5], acc0); end
    n_cmp++; if (got_en !== 0) begin n_fail++; $display("FAIL imm_halt_cpu_en: got %0d expected 0", got_en); end
    n_cmp++; if (got_first_tx !== 1) begin n_fail++; $display("FAIL imm_halt_tx_latency: got %0d expected 1", got_first_tx); end
    n_cmp++; if (got_starts !== 6 || hung !== 0) begin n_fail++; $display("FAIL imm_halt_bytes: got %0d hung=%0d expected 6 hung=0", got_starts, hung); end
  endtask

  task automatic test_timeout();
    logic [15:0] acc0;
    acc0 = 16'h1230;
    for (int i = 0; i < 2048; i++) pmem[i] = 16'h2801; // ADDI 1, never HALT
    sel = 1'b1;
    load_cpu(acc0);
    do_run(5, 0);
    n_cmp++; if ({got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]} !== 48'h000A_123A_000A) begin
      n_fail++; $display("FAIL timeout_frame: got %h %h %h %h %h %h expected 00 0a 12 3a 00 0a",
        got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]); end
    n_cmp++; if (got_en !== 10) begin n_fail++; $display("FAIL timeout_cpu_en_cycles: got %0d expected 10", got_en); end
    n_cmp++; if (got_first_tx !== 11) begin n_fail++; $display("FAIL timeout_tx_latency: got %0d expected 11", got_first_tx); end
    n_cmp++; if (got_starts !== 6 || gap_err + hold_err + extra_err + hung !== 0) begin
      n_fail++; $display("FAIL timeout_handshake: got starts=%0d errs=%0d expected 6/0", got_starts, gap_err + hold_err + extra_err + hung); end
    sel = 1'b0;
    clear_prog();
  endtask

  task automatic test_handshake_random();
    logic [15:0] acc0;
    logic [47:0] exp_fr;
    int len, exp_cnt;
    for (int it = 0; it < 8; it++) begin
      clear_prog();
      len = $urandom_range(20, 0);
      for (int i = 0; i < len; i++)
        pmem[i] = {5'($urandom_range(7, 1)), 11'($urandom_range(2047, 0))};
      acc0 = 16'($urandom_range(65535, 0));
      exp_fr = ref_frame(acc0, 65535, exp_cnt);
      load_cpu(acc0);
      do_run(20, (it % 2) == 1);
      n_cmp++; if ({got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]} !== exp_fr) begin
        n_fail++; $display("FAIL rand_frame[%0d]: got %h%h%h%h%h%h expected %h", it,
          got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5], exp_fr); end
      n_cmp++; if (got_en !== exp_cnt) begin n_fail++; $display("FAIL rand_cpu_en[%0d]: got %0d expected %0d", it, got_en, exp_cnt); end
      n_cmp++; if (got_first_tx !== exp_cnt + 1) begin n_fail++; $display("FAIL rand_tx_latency[%0d]: got %0d expected %0d", it, got_first_tx, exp_cnt + 1); end
      n_cmp++; if (got_starts !== 6 || got_acks !== 6) begin n_fail++; $display("FAIL rand_bytes[%0d]: got %0d/%0d expected 6/6", it, got_starts, got_acks); end
      n_cmp++; if (gap_err + hold_err + extra_err + hung !== 0) begin
        n_fail++; $display("FAIL rand_handshake[%0d]: got gap=%0d hold=%0d extra=%0d hung=%0d expected all 0", it, gap_err, hold_err, extra_err, hung); end
    end
  endtask

  task automatic test_reset_mid_dump();
    int  starts, bad;
    bit  ack_next, reached;
    set_normal_prog();
    load_cpu(16'h0000);
    @(posedge clk); #1;
    rx_data = START_CMD; rx_done = 1'b1;
    starts = 0; ack_next = 0; reached = 0;
    for (int c = 0; c < 300 && !reached; c++) begin
      @(posedge clk); #1;
      rx_done = 1'b0; tx_done = 1'b0;
      if (ack_next) begin tx_done = 1'b1; ack_next = 0; end
      if (tx_start) begin
        starts++;
        if (starts < 3) ack_next = 1; else reached = 1;
      end
    end
    n_cmp++; if (reached !== 1'b1) begin n_fail++; $display("FAIL rst_dump_reach_byte3: got %0d bytes expected 3", starts); end
    @(posedge clk); #1;
    tx_done = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    tx_done = 1'b0;
    n_cmp++; if (busy !== 1'b0 || tx_start !== 1'b0 || cpu_en !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_dump_outputs: got busy=%b tx_start=%b cpu_en=%b tx_data=%h expected 0/0/0/00", busy, tx_start, cpu_en, tx_data); end
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      tx_done = 1'($urandom_range(1, 0));
      if (tx_start || busy) bad++;
    end
    tx_done = 1'b0;
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rst_dump_no_resume: got %0d active cycles expected 0", bad); end
    set_normal_prog();
    load_cpu(16'h0000);
    do_run(1, 0);
    n_cmp++; if ({got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]} !== 48'h0003_0008_0003) begin
      n_fail++; $display("FAIL rst_dump_rerun_frame: got %h %h %h %h %h %h expected 00 03 00 08 00 03",
        got_frame[0], got_frame[1], got_frame[2], got_frame[3], got_frame[4], got_frame[5]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    sel = 1'b0; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
    rst_n = 1'b0; cpu_load = 1'b1; load_acc = 16'h0000;
    clear_prog();
    test_reset();
    test_normal_run();
    test_wrong_cmd();
    test_immediate_halt();
    test_timeout();
    test_handshake_random();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
